prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Program loader directly upstream of the SEQ processor's fetch stage.
- Accepts a byte-serial Y86 program over a valid/ready stream and writes it into instruction memory from address 0.
- Zero-fills the rest of memory so stale bytes are never fetched, then releases the processor.
- Monitors the processor status code and latches the final status when execution stops.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes.
- ADDR_W, 10, memory address width; requires 2**ADDR_W >= MEM_BYTES.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  program byte valid
- in_byte  input  8  program byte
- in_last  input  1  marks final program byte
- in_ready  output  1  loader accepts byte this cycle
- mem_we  output  1  instruction memory write strobe
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  8  write data
- cpu_stat  input  4  processor status: 8=AOK, 2=HLT, 4=INS, 1=ADR
- run_en  output  1  processor enable; high only in RUN
- start_cpu  output  1  one-cycle pulse on entry to RUN; processor resets its PC to 0
- reload_req  input  1  request a new load from DONE or ERROR
- byte_count  output  ADDR_W+1  program bytes accepted
- final_stat  output  4  status latched when the processor stopped
- load_err  output  1  overflow or checksum error
- state_o  output  3  current state encoding, for debug

Behaviour:
- States and encodings: LOAD=0, FILL=1, RUN=2, DONE=3, ERROR=4.
- Reset (synchronous; overrides everything, including mid-load and mid-run):
  - state=LOAD, byte_count=0, final_stat=4'b1000, load_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, run_en=0, start_cpu=0.
- LOAD:
  - in_ready=1.
  - A byte is accepted when in_valid && in_ready.
  - Registered write: next cycle mem_we=1, mem_addr=byte_count, mem_wdata=in_byte. byte_count then increments. Write latency is 1 cycle.
  - Accepted byte with in_last=1:
    - byte_count < MEM_BYTES after increment → FILL.
    - byte_count == MEM_BYTES → RUN directly.
  - Accepted byte with in_last=0 that makes byte_count == MEM_BYTES → ERROR, load_err=1 (overflow).
  - No accepted byte → mem_we=0 next cycle; in_valid gaps of any length are allowed.
- FILL:
  - in_ready=0.
  - Writes 8'h00 each cycle at addresses byte_count .. MEM_BYTES-1, one per cycle; byte_count is not changed.
  - After the write to MEM_BYTES-1 → RUN.
  - Total FILL duration is MEM_BYTES - byte_count cycles.
- RUN:
  - start_cpu=1 in the first cycle only; run_en=1 throughout; mem_we=0; in_ready=0.
  - cpu_stat is sampled each cycle starting with the cycle after start_cpu.
  - cpu_stat != 4'b1000 → final_stat <= cpu_stat, go to DONE. This covers 2=HLT, 4=INS, 1=ADR and any other code.
- DONE:
  - run_en=0; final_stat is held.
  - reload_req=1 → LOAD; byte_count=0; load_err is cleared; final_stat is reset to 4'b1000.
- ERROR:
  - run_en=0, in_ready=0, load_err=1.
  - reload_req → LOAD, same clearing as from DONE.
- reload_req is ignored in LOAD, FILL and RUN.
- Empty program: not representable. A single byte with in_last=1 is the minimum program; e.g. 8'h00 (halt) gives HLT on the first instruction.
- Simultaneous in_valid and reset: reset wins and the byte is dropped.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum (mod 256) of all program bytes is kept.
  - The byte following the in_last byte is a checksum byte; it is consumed in a state CHECK=5 and is not written to memory.
  - Match → FILL, or RUN if memory is full.
  - Mismatch → ERROR with load_err=1.
  - A program of exactly MEM_BYTES bytes still consumes its checksum byte.
- Disabled: CHECK state absent; behaviour exactly as above.

Test Plan:
- Load 3 bytes {30,F0,00} with in_last on the third, MEM_BYTES=16 → writes at addr 0,1,2; zeros at 3..15 over 13 FILL cycles; start_cpu pulses once; byte_count=3.
- In RUN, drive cpu_stat=8 for 5 cycles then 2 → DONE, final_stat=2, run_en=0 the next cycle.
- Stream 16 bytes with no in_last, MEM_BYTES=16 → ERROR, load_err=1, in_ready=0. Then pulse reload_req → LOAD, byte_count=0, load_err=0.
- Assert reset during FILL after 4 zero writes → next cycle state=LOAD, mem_we=0, byte_count=0, run_en=0.
- Bytes with random in_valid gaps (valid on 1 of every 3 cycles), 5-byte program → addresses written 0..4 in order, no duplicate or skipped writes.
- Checksum enabled, bytes {10,20} then check byte 30 → RUN. Repeat with check byte 31 → ERROR, load_err=1.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-serial program loader in front of the SEQ fetch stage: load, zero-fill, run, latch stop status.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [3:0]        cpu_stat,
  output logic              run_en,
  output logic              start_cpu,
  input  logic              reload_req,
  output logic [ADDR_W:0]   byte_count,
  output logic [3:0]        final_stat,
  output logic              load_err,
  output logic [2:0]        state_o
);

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd5;
`endif

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_BYTES - 1);
  localparam logic [3:0]        STAT_AOK   = 4'b1000;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [3:0]        final_stat_q, final_stat_d;
  logic              load_err_q, load_err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              start_cpu_q, start_cpu_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic            accept;
  logic [ADDR_W:0] count_inc;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign in_ready = (state_q == ST_LOAD);
`endif
  assign accept    = in_valid && in_ready;
  assign count_inc = byte_count_q + (ADDR_W+1)'(1);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d      = state_q;
    byte_count_d = byte_count_q;
    fill_addr_d  = fill_addr_q;
    final_stat_d = final_stat_q;
    load_err_d   = load_err_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    start_cpu_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = byte_count_q[ADDR_W-1:0];
          mem_wdata_d  = in_byte;
          byte_count_d = count_inc;
          fill_addr_d  = count_inc[ADDR_W-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d        = sum_q + in_byte;
`endif
          if (in_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            if (count_inc == FULL_COUNT) begin
              state_d     = ST_RUN;
              start_cpu_d = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
`endif
          end else if (count_inc == FULL_COUNT) begin
            state_d    = ST_ERROR;
            load_err_d = 1'b1;
          end
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      // The checksum byte is consumed here and never written to memory.
      ST_CHECK: begin
        if (accept) begin
          if (in_byte == sum_q) begin
            if (byte_count_q == FULL_COUNT) begin
              state_d     = ST_RUN;
              start_cpu_d = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            state_d    = ST_ERROR;
            load_err_d = 1'b1;
          end
        end
      end
`endif

      // Writes are registered, so the final zero write lands in the first RUN cycle.
      ST_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = fill_addr_q;
        mem_wdata_d = 8'h00;
        fill_addr_d = fill_addr_q + ADDR_W'(1);
        if (fill_addr_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          start_cpu_d = 1'b1;
        end
      end

      // The processor is still resetting its PC during the start_cpu cycle, so its status is ignored then.
      ST_RUN: begin
        if (!start_cpu_q && (cpu_stat != STAT_AOK)) begin
          final_stat_d = cpu_stat;
          state_d      = ST_DONE;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (reload_req) begin
          state_d      = ST_LOAD;
          byte_count_d = '0;
          load_err_d   = 1'b0;
          final_stat_d = STAT_AOK;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q      <= ST_LOAD;
      byte_count_q <= '0;
      fill_addr_q  <= '0;
      final_stat_q <= STAT_AOK;
      load_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      start_cpu_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      fill_addr_q  <= fill_addr_d;
      final_stat_q <= final_stat_d;
      load_err_q   <= load_err_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      start_cpu_q  <= start_cpu_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign run_en     = (state_q == ST_RUN);
  assign start_cpu  = start_cpu_q;
  assign byte_count = byte_count_q;
  assign final_stat = final_stat_q;
  assign load_err   = load_err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory image per program is queued, a monitor checks every write.
// Checksum scenarios are compiled in when PROG_LOADER_CHECKSUM_EN is defined for both bench and design.
module tb_prog_loader;

  localparam int MEM = 16;
  localparam int AW  = 4;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [3:0]    cpu_stat;
  logic          run_en;
  logic          start_cpu;
  logic          reload_req;
  logic [AW:0]   byte_count;
  logic [3:0]    final_stat;
  logic          load_err;
  logic [2:0]    state_o;

  always #5 clock = ~clock;

  prog_loader #(.MEM_BYTES(MEM), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_stat(cpu_stat), .run_en(run_en), .start_cpu(start_cpu), .reload_req(reload_req),
    .byte_count(byte_count), .final_stat(final_stat), .load_err(load_err), .state_o(state_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] prog[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected image entry, in order.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference image: program bytes at 0..n-1, then zeros up to (but excluding) upto.
  task automatic push_image(input int upto);
    for (int a = 0; a < upto; a++) begin
      if (a < prog.size()) exp_q.push_back('{addr: AW'(a), data: prog[a]});
      else                 exp_q.push_back('{addr: AW'(a), data: 8'h00});
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_last = 1'($urandom);
      in_byte = 8'($urandom);
      step();
    end
    in_last = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int gap);
    idle(gap);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    check("in_ready_on_byte", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_program(input int gap_min, input int gap_max);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < prog.size(); i++) begin
      sum = sum + prog[i];
      send(prog[i], (i == prog.size() - 1), $urandom_range(gap_max, gap_min));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(sum, 1'b0, $urandom_range(gap_max, gap_min));
`endif
  endtask

  task automatic reload_and_check(input string tag);
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    check({tag, "_state"},      32'(state_o),    32'(S_LOAD));
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    check({tag, "_load_err"},   32'(load_err),   32'd0);
    check({tag, "_final_stat"}, 32'(final_stat), 32'h8);
  endtask

  task automatic run_to_done(input logic [3:0] stat, input int k);
    int fill  = 0;
    int guard = 0;
    while (state_o !== S_RUN && guard < 4 * MEM) begin
      if (state_o === S_FILL) fill++;
      step();
      guard++;
    end
    check("reach_run",      32'(state_o),    32'(S_RUN));
    check("fill_cycles",    32'(fill),       32'(MEM - prog.size()));
    check("start_pulse",    32'(start_cpu),  32'd1);
    check("run_en",         32'(run_en),     32'd1);
    check("in_ready_run",   32'(in_ready),   32'd0);
    check("byte_count_run", 32'(byte_count), 32'(prog.size()));
    // Status during the start cycle and reload requests in RUN must both be ignored.
    cpu_stat   = 4'($urandom_range(7, 0));
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    cpu_stat   = 4'h8;
    check("start_cycle_stat_ignored", 32'(state_o),   32'(S_RUN));
    check("start_single",             32'(start_cpu), 32'd0);
    check("run_no_write",             32'(mem_we),    32'd0);
    repeat (k) step();
    check("run_on_aok", 32'(state_o), 32'(S_RUN));
    cpu_stat = stat;
    step();
    cpu_stat = 4'h8;
    check("done_state",  32'(state_o),    32'(S_DONE));
    check("final_stat",  32'(final_stat), 32'(stat));
    check("done_run_en", 32'(run_en),     32'd0);
    repeat (2) step();
    check("final_stat_held", 32'(final_stat), 32'(stat));
    reload_and_check("reload_done");
  endtask

  task automatic run_program(input int gap_min, input int gap_max, input logic [3:0] stat, input int k);
    push_image(MEM);
    load_program(gap_min, gap_max);
    run_to_done(stat, k);
  endtask

  function automatic logic [3:0] pick_stat();
    logic [3:0] s;
    case ($urandom_range(3, 0))
      0:       s = 4'h2;
      1:       s = 4'h4;
      2:       s = 4'h1;
      default: begin
        s = 4'($urandom);
        if (s == 4'h8) s = 4'hF;
      end
    endcase
    return s;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    cpu_stat = 4'h8; reload_req = 1'b0;
    repeat (2) step();
    check("rst_state",      32'(state_o),    32'(S_LOAD));
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_final_stat", 32'(final_stat), 32'h8);
    check("rst_load_err",   32'(load_err),   32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    check("rst_run_en",     32'(run_en),     32'd0);
    check("rst_start_cpu",  32'(start_cpu),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    reset = 1'b0;

    // Three-byte program, halts after five AOK cycles.
    prog = '{8'h30, 8'hF0, 8'h00};
    run_program(0, 0, 4'h2, 5);

    // Overflow: a full memory of bytes without in_last.
    prog.delete();
    for (int i = 0; i < MEM; i++) prog.push_back(8'($urandom));
    push_image(MEM);
    for (int i = 0; i < MEM; i++) send(prog[i], 1'b0, $urandom_range(1, 0));
    check("ovf_state",      32'(state_o),    32'(S_ERROR));
    check("ovf_load_err",   32'(load_err),   32'd1);
    check("ovf_in_ready",   32'(in_ready),   32'd0);
    check("ovf_run_en",     32'(run_en),     32'd0);
    check("ovf_byte_count", 32'(byte_count), 32'(MEM));
    in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    check("ovf_held", 32'(state_o), 32'(S_ERROR));
    reload_and_check("reload_err");

    // Reset after four zero writes; reload during FILL must be ignored, and a byte presented with reset is dropped.
    begin
      int guard = 0;
      prog.delete();
      for (int i = 0; i < 3; i++) prog.push_back(8'($urandom));
      push_image(7);
      load_program(0, 1);
      reload_req = 1'b1;
      while (!(mem_we === 1'b1 && mem_addr === AW'(6)) && guard < 4 * MEM) begin
        step();
        guard++;
      end
      check("fill_progress", 32'(mem_addr), 32'd6);
      reload_req = 1'b0;
      reset      = 1'b1;
      in_valid   = 1'b1;
      in_byte    = 8'hA5;
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("mid_rst_state",      32'(state_o),    32'(S_LOAD));
      check("mid_rst_mem_we",     32'(mem_we),     32'd0);
      check("mid_rst_byte_count", 32'(byte_count), 32'd0);
      check("mid_rst_run_en",     32'(run_en),     32'd0);
      step();
      check("mid_rst_no_write",   32'(mem_we),     32'd0);
    end

    // Five-byte program with a valid byte only every third cycle.
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(8'($urandom));
    run_program(2, 2, 4'h4, 3);

    // Program filling memory exactly: no FILL, direct RUN.
    prog.delete();
    for (int i = 0; i < MEM; i++) prog.push_back(8'($urandom));
    run_program(0, 1, 4'h1, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    prog = '{8'h10, 8'h20};
    push_image(MEM);
    send(8'h10, 1'b0, 0);
    send(8'h20, 1'b1, 0);
    send(8'h30, 1'b0, 1);
    run_to_done(4'h2, 2);

    prog = '{8'h10, 8'h20};
    push_image(2);
    send(8'h10, 1'b0, 0);
    send(8'h20, 1'b1, 0);
    send(8'h31, 1'b0, 0);
    check("cks_bad_state",    32'(state_o),  32'(S_ERROR));
    check("cks_bad_load_err", 32'(load_err), 32'd1);
    reload_and_check("reload_cks");
`endif

    // Randomized programs, gaps and stop codes.
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(MEM, 1);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      run_program(0, 3, pick_stat(), $urandom_range(6, 0));
    end

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
